sram_dp_ctrl: RTL and testbench

Parametrised simple-dual-port synchronous SRAM block, the successor to the team's single-port 8x8 SRAM. Independent write and read ports per cycle, byte-lane write enables, selectable read latency, valid-qualified read data and a hardware clear sweep after reset or on request. It sits between a producer writing buffered data and a consumer reading it back, standing alone as a local scratch or buffer memory.

---
 rtl/sram_dp_pkg.sv | 15 +
 rtl/sram_dp_bank.sv | 37 +++
 rtl/sram_dp_ctrl.sv | 156 +++++++++++++++
 tb/tb_sram_dp_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_dp_pkg.sv
// Shared types and constants for the simple-dual-port SRAM block.
package sram_dp_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    localparam int unsigned LANE_W = 8;

    function automatic int unsigned lane_count(input int unsigned data_w);
        return data_w / LANE_W;
    endfunction

endpackage

// File: rtl/sram_dp_bank.sv
// Storage array: byte-enabled synchronous write, registered synchronous read.
module sram_dp_bank
    import sram_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [lane_count(DATA_W)-1:0] wbe,
    input  logic [DATA_W-1:0]             wdata,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             raddr,
    output logic [DATA_W-1:0]             rdata
);

    localparam int unsigned LANES = lane_count(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Callers only assert we/re with in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sram_dp_ctrl.sv
// Simple-dual-port SRAM controller: clear sweep FSM, range checks,
// write-first collision bypass, 1/2-cycle read pipeline with valid strobe.
module sram_dp_ctrl
    import sram_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [lane_count(DATA_W)-1:0] wr_be,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          ready
);

    localparam int unsigned       LANES   = lane_count(DATA_W);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;

    logic              wr_in, rd_in, accept_wr, accept_rd;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr;
    logic [LANES-1:0]  bank_wbe;
    logic [DATA_W-1:0] bank_wdata, bank_rdata;
    logic [DATA_W-1:0] wr_mask;

    logic              s1_valid, s1_zero;
    logic [DATA_W-1:0] s1_mask, s1_byp, s1_data;

    assign wr_in = {1'b0, wr_addr} < DEPTH_X;
    assign rd_in = {1'b0, rd_addr} < DEPTH_X;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ready      = 1'b0;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        bank_we    = 1'b0;
        bank_waddr = wr_addr;
        bank_wbe   = wr_be;
        bank_wdata = wr_data;
        case (state)
            CLEAR: begin
                bank_we    = 1'b1;
                bank_waddr = cnt;
                bank_wbe   = '1;
                bank_wdata = '0;
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            IDLE: begin
                ready = 1'b1;
                if (clr) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end else begin
                    accept_wr = wr_en && wr_in;
                    accept_rd = rd_en;
                    bank_we   = accept_wr;
                end
            end
        endcase
    end

    always_comb begin
        wr_mask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            wr_mask[i*LANE_W +: LANE_W] = {LANE_W{wr_be[i]}};
        end
    end

    sram_dp_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wbe   (bank_wbe),
        .wdata (bank_wdata),
        .re    (accept_rd && rd_in),
        .raddr (rd_addr),
        .rdata (bank_rdata)
    );

    // s1_zero resets high so the unreset bank output never reaches rd_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b1;
            s1_mask  <= '0;
            s1_byp   <= '0;
        end else begin
            s1_valid <= accept_rd;
            if (accept_rd) begin
                s1_zero <= !rd_in;
                s1_mask <= (accept_wr && (wr_addr == rd_addr)) ? wr_mask : '0;
                s1_byp  <= wr_data;
            end
        end
    end

    assign s1_data = s1_zero ? '0 : ((bank_rdata & ~s1_mask) | (s1_byp & s1_mask));

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] out_q;
        logic              out_v;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                out_q <= '0;
                out_v <= 1'b0;
            end else begin
                out_v <= s1_valid;
                if (s1_valid) begin
                    out_q <= s1_data;
                end
            end
        end

        assign rd_data  = out_q;
        assign rd_valid = out_v;
    end else begin : g_lat1
        assign rd_data  = s1_data;
        assign rd_valid = s1_valid;
    end

endmodule

// File: tb/tb_sram_dp_ctrl.sv
// Directed bench: three configurations (8b/lat1, 32b/lat2, depth-6) sharing clk and rst.
module tb_sram_dp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    // u0: DATA_W=8, DEPTH=8, RD_LAT=1
    logic       clr0 = 0, we0 = 0, re0 = 0;
    logic [2:0] wa0 = 0, ra0 = 0;
    logic [0:0] wb0 = 0;
    logic [7:0] wd0 = 0, rd0;
    logic       rv0, rdy0;

    // u1: DATA_W=32, DEPTH=8, RD_LAT=2
    logic        clr1 = 0, we1 = 0, re1 = 0;
    logic [2:0]  wa1 = 0, ra1 = 0;
    logic [3:0]  wb1 = 0;
    logic [31:0] wd1 = 0, rd1;
    logic        rv1, rdy1;

    // u2: DATA_W=8, DEPTH=6, RD_LAT=1
    logic       clr2 = 0, we2 = 0, re2 = 0;
    logic [2:0] wa2 = 0, ra2 = 0;
    logic [0:0] wb2 = 0;
    logic [7:0] wd2 = 0, rd2;
    logic       rv2, rdy2;

    sram_dp_ctrl #(.DATA_W(8), .ADDR_W(3), .DEPTH(8), .RD_LAT(1)) u0 (
        .clk(clk), .rst(rst), .clr(clr0), .wr_en(we0), .wr_addr(wa0), .wr_be(wb0),
        .wr_data(wd0), .rd_en(re0), .rd_addr(ra0), .rd_data(rd0), .rd_valid(rv0), .ready(rdy0));

    sram_dp_ctrl #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .RD_LAT(2)) u1 (
        .clk(clk), .rst(rst), .clr(clr1), .wr_en(we1), .wr_addr(wa1), .wr_be(wb1),
        .wr_data(wd1), .rd_en(re1), .rd_addr(ra1), .rd_data(rd1), .rd_valid(rv1), .ready(rdy1));

    sram_dp_ctrl #(.DATA_W(8), .ADDR_W(3), .DEPTH(6), .RD_LAT(1)) u2 (
        .clk(clk), .rst(rst), .clr(clr2), .wr_en(we2), .wr_addr(wa2), .wr_be(wb2),
        .wr_data(wd2), .rd_en(re2), .rd_addr(ra2), .rd_data(rd2), .rd_valid(rv2), .ready(rdy2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // Reset held
        tick(); tick();
        check("rst_ready", 32'(rdy0), 0);
        check("rst_valid", 32'(rv0), 0);
        check("rst_data", 32'(rd0), 0);
        check("rst_data_l2", rd1, 0);
        rst = 1'b1;

        // Initial sweep: DEPTH edges
        for (int i = 0; i < 8; i++) begin
            tick();
            check("sweep_ready0", 32'(rdy0), 32'(i == 7));
            check("sweep_ready2", 32'(rdy2), 32'(i >= 5));
        end

        // Back-to-back reads of the cleared array
        for (int a = 0; a < 8; a++) begin
            re0 = 1; ra0 = 3'(a);
            tick();
            check("init_rd_valid", 32'(rv0), 1);
            check("init_rd_data", 32'(rd0), 0);
        end
        re0 = 0;
        tick();
        check("idle_valid", 32'(rv0), 0);

        // Same-cycle write/read, write-first
        we0 = 1; wa0 = 5; wd0 = 8'h5A; wb0 = 1; re0 = 1; ra0 = 5;
        tick();
        check("bypass_valid", 32'(rv0), 1);
        check("bypass_data", 32'(rd0), 32'h5A);
        we0 = 0;
        tick();
        check("after_bypass", 32'(rd0), 32'h5A);
        re0 = 0;

        // Fill with 0xFF, then clr with a read just before it
        for (int a = 0; a < 8; a++) begin
            we0 = 1; wa0 = 3'(a); wd0 = 8'hFF; wb0 = 1;
            tick();
        end
        we0 = 0; re0 = 1; ra0 = 2;
        tick();
        check("pre_clr_rd", 32'(rd0), 32'hFF);
        clr0 = 1; re0 = 1; ra0 = 3; we0 = 1; wa0 = 4; wd0 = 8'h12;
        tick();
        clr0 = 0;
        check("clr_ready", 32'(rdy0), 0);
        check("clr_drop_rd", 32'(rv0), 0);
        check("clr_hold_data", 32'(rd0), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            we0 = 1; wa0 = 3'(i); wd0 = 8'h33; re0 = 1; ra0 = 3'(i);
            tick();
            check("clr_sweep_ready", 32'(rdy0), 32'(i == 7));
            check("clr_sweep_valid", 32'(rv0), 0);
        end
        we0 = 0;
        for (int a = 0; a < 8; a++) begin
            re0 = 1; ra0 = 3'(a);
            tick();
            check("post_clr_valid", 32'(rv0), 1);
            check("post_clr_data", 32'(rd0), 0);
        end
        re0 = 0;

        // u1: byte lanes and RD_LAT=2
        we1 = 1; wa1 = 3; wd1 = 32'hAABBCCDD; wb1 = 4'b1111;
        tick();
        wd1 = 32'h11223344; wb1 = 4'b0101;
        tick();
        wa1 = 1; wd1 = 32'hFFFFFFFF; wb1 = 4'b0000;
        tick();
        we1 = 0; re1 = 1; ra1 = 3;
        tick();
        re1 = 1; ra1 = 1;
        check("l2_lat_not_yet", 32'(rv1), 0);
        tick();
        re1 = 0;
        check("l2_valid", 32'(rv1), 1);
        check("l2_lane_data", rd1, 32'hAA22CC44);
        tick();
        check("l2_be0_valid", 32'(rv1), 1);
        check("l2_be0_data", rd1, 0);
        tick();
        check("l2_idle_valid", 32'(rv1), 0);

        // u1: read in flight across clr
        re1 = 1; ra1 = 3;
        tick();
        re1 = 0; clr1 = 1;
        tick();
        clr1 = 0;
        check("l2_inflight_valid", 32'(rv1), 1);
        check("l2_inflight_data", rd1, 32'hAA22CC44);
        check("l2_clr_ready", 32'(rdy1), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("l2_sweep_ready", 32'(rdy1), 32'(i == 7));
        end
        re1 = 1; ra1 = 3;
        tick();
        re1 = 0;
        tick();
        check("l2_post_clr_valid", 32'(rv1), 1);
        check("l2_post_clr_data", rd1, 0);

        // u2: DEPTH=6, out-of-range accesses
        for (int a = 0; a < 6; a++) begin
            we2 = 1; wa2 = 3'(a); wd2 = 8'(a + 16); wb2 = 1;
            tick();
        end
        wa2 = 6; wd2 = 8'h77;
        tick();
        wa2 = 7;
        tick();
        we2 = 0;
        for (int a = 6; a < 8; a++) begin
            re2 = 1; ra2 = 3'(a);
            tick();
            check("oor_valid", 32'(rv2), 1);
            check("oor_data", 32'(rd2), 0);
        end
        for (int a = 0; a < 6; a++) begin
            re2 = 1; ra2 = 3'(a);
            tick();
            check("inrange_data", 32'(rd2), 32'(a + 16));
        end
        re2 = 0;

        // Reset mid-sweep (cnt=4) with a u1 read in flight
        we0 = 1; wa0 = 1; wd0 = 8'h9C; wb0 = 1;
        tick();
        we0 = 0; re0 = 1; ra0 = 1;
        tick();
        re0 = 0;
        check("pre_rst_data", 32'(rd0), 32'h9C);
        clr0 = 1;
        tick();
        clr0 = 0;
        tick(); tick(); tick();
        re1 = 1; ra1 = 0;
        tick();
        re1 = 0;
        check("mid_sweep_ready", 32'(rdy0), 0);
        rst = 1'b0;
        #1;
        check("mrst_ready", 32'(rdy0), 0);
        check("mrst_valid", 32'(rv0), 0);
        check("mrst_data", 32'(rd0), 0);
        check("mrst_l2_valid", 32'(rv1), 0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mrst_sweep_ready", 32'(rdy0), 32'(i == 7));
            check("mrst_flush_l2", 32'(rv1), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
